// File: rtl/string_match_engine.sv
// string_match_engine
//   Receives a string (up to 32 chars) and then one or more patterns (up to 8
//   chars each). For every pattern it scans candidate start positions
//   s = 0..len, one per cycle, and reports the lowest s where the pattern
//   matches.
//   Pattern rules:
//     '.'                   matches any single character.
//     '^' at position 0     zero-width anchor: s is 0 or follows a space.
//     '$' at last position  zero-width anchor: end is len or precedes a space.
//     '^' or '$' anywhere else is matched literally.
//   The stored string persists across patterns.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   chardata     in   [7:0] character sampled on clk rise
//   isstring     in   chardata is a string character (wins over ispattern)
//   ispattern    in   chardata is a pattern character
//   valid        out  one-cycle result strobe per pattern
//   match        out  pattern found (qualified by valid, held otherwise)
//   match_index  out  [4:0] start position of the match (qualified by valid)
module string_match_engine (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] chardata,
  input  logic       isstring,
  input  logic       ispattern,
  output logic       valid,
  output logic       match,
  output logic [4:0] match_index
);

  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  typedef enum logic [2:0] {IDLE, RX_STR, RX_PAT, SEARCH, OUT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  str_q [32];
  logic [7:0]  str_d [32];
  logic [7:0]  pat_q [8];
  logic [7:0]  pat_d [8];
  logic [5:0]  len_q, len_d;
  logic [3:0]  plen_q, plen_d;
  logic [5:0]  s_q, s_d;
  logic        match_q, match_d;
  logic [4:0]  idx_q, idx_d;

  // Candidate evaluation for the current start position s_q
  logic        hs, he;
  logic [2:0]  last;
  logic [3:0]  blen;
  logic [6:0]  span_end;
  logic        span_ok, chars_ok, start_ok, end_ok, cand_pass;
  logic [7:0]  pc, sc;
  logic [6:0]  si;

  always_comb begin
    hs       = (plen_q != 4'd0) && (pat_q[0] == CH_CARET);
    last     = 3'(plen_q - 4'd1);
    // A lone "^" is a start anchor; its last char is not '$', so no overlap.
    he       = (plen_q != 4'd0) && (pat_q[last] == CH_DOLLAR);
    blen     = plen_q - {3'b000, hs} - {3'b000, he};
    span_end = {1'b0, s_q} + {3'b000, blen};
    span_ok  = span_end <= {1'b0, len_q};
    chars_ok = 1'b1;
    pc       = '0;
    sc       = '0;
    si       = '0;
    // All body characters are compared against the string in parallel.
    for (int unsigned k = 0; k < 8; k++) begin
      if (4'(k) < blen) begin
        pc = pat_q[3'(4'(k) + {3'b000, hs})];
        si = {1'b0, s_q} + 7'(k);
        sc = (si < 7'd32) ? str_q[si[4:0]] : 8'h00;
        if ((pc != CH_DOT) && (pc != sc)) chars_ok = 1'b0;
      end
    end
    start_ok  = !hs || (s_q == 6'd0) || (str_q[5'(s_q - 6'd1)] == CH_SPACE);
    end_ok    = !he || (span_end == {1'b0, len_q}) ||
                ((span_end < 7'd32) && (str_q[span_end[4:0]] == CH_SPACE));
    cand_pass = span_ok && chars_ok && start_ok && end_ok;
  end

  // Next-state logic
  logic start_str, app_str, start_pat, app_pat;

  always_comb begin
    state_d   = state_q;
    str_d     = str_q;
    pat_d     = pat_q;
    len_d     = len_q;
    plen_d    = plen_q;
    s_d       = s_q;
    match_d   = match_q;
    idx_d     = idx_q;
    start_str = 1'b0;
    app_str   = 1'b0;
    start_pat = 1'b0;
    app_pat   = 1'b0;

    case (state_q)
      IDLE: begin
        if (isstring)       start_str = 1'b1;
        else if (ispattern) start_pat = 1'b1;
      end
      RX_STR: begin
        if (isstring)       app_str   = 1'b1;
        else if (ispattern) start_pat = 1'b1;
        else                state_d   = IDLE;
      end
      RX_PAT: begin
        if (isstring)       start_str = 1'b1;
        else if (ispattern) app_pat   = 1'b1;
        else begin
          state_d = SEARCH;
          s_d     = '0;
        end
      end
      SEARCH: begin
        if (cand_pass) begin
          match_d = 1'b1;
          idx_d   = s_q[4:0];
          state_d = OUT;
        end else if (s_q == len_q) begin
          match_d = 1'b0;
          idx_d   = '0;
          state_d = OUT;
        end else begin
          s_d = s_q + 6'd1;
        end
      end
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (start_str) begin
      for (int unsigned i = 0; i < 32; i++) str_d[i] = '0;
      str_d[0] = chardata;
      len_d    = 6'd1;
      state_d  = RX_STR;
    end
    if (app_str && (len_q < 6'd32)) begin
      str_d[len_q[4:0]] = chardata;
      len_d             = len_q + 6'd1;
    end
    if (start_pat) begin
      for (int unsigned i = 0; i < 8; i++) pat_d[i] = '0;
      pat_d[0] = chardata;
      plen_d   = 4'd1;
      state_d  = RX_PAT;
    end
    if (app_pat && (plen_q < 4'd8)) begin
      pat_d[plen_q[2:0]] = chardata;
      plen_d             = plen_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      for (int unsigned i = 0; i < 32; i++) str_q[i] <= '0;
      for (int unsigned i = 0; i < 8; i++)  pat_q[i] <= '0;
      len_q   <= '0;
      plen_q  <= '0;
      s_q     <= '0;
      match_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      str_q   <= str_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      plen_q  <= plen_d;
      s_q     <= s_d;
      match_q <= match_d;
      idx_q   <= idx_d;
    end
  end

  assign valid       = (state_q == OUT);
  assign match       = match_q;
  assign match_index = idx_q;

endmodule

// File: tb/tb_string_match_engine.sv
module tb_string_match_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       valid;
  logic       match;
  logic [4:0] match_index;

  always #5 clk = ~clk;

  string_match_engine dut (
    .clk         (clk),
    .reset       (reset),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .valid       (valid),
    .match       (match),
    .match_index (match_index)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: search the (truncated) string for the (truncated) pattern.
  function automatic void ref_match(input string s, input string p,
                                    output bit m, output int idx);
    string st, pt, body;
    int    sl, pl, bl, e;
    bit    hs, he, ok;
    st = (s.len() > 32) ? s.substr(0, 31) : s;
    pt = (p.len() > 8)  ? p.substr(0, 7)  : p;
    sl = st.len();
    pl = pt.len();
    hs = (pl > 0) && (pt[0] == 8'h5E);
    he = (pl > 0) && (pt[pl-1] == 8'h24) && !(hs && pl == 1);
    body = "";
    for (int i = int'(hs); i < pl - int'(he); i++) body = {body, pt.substr(i, i)};
    bl  = body.len();
    m   = 1'b0;
    idx = 0;
    for (int a = 0; a <= sl; a++) begin
      if (!m && (a + bl <= sl)) begin
        ok = 1'b1;
        for (int k = 0; k < bl; k++)
          if (body[k] != 8'h2E && body[k] != st[a+k]) ok = 1'b0;
        if (hs && a != 0 && st[a-1] != 8'h20) ok = 1'b0;
        e = a + bl;
        if (he && e != sl && st[e] != 8'h20) ok = 1'b0;
        if (ok) begin
          m   = 1'b1;
          idx = a;
        end
      end
    end
  endfunction

  function automatic string rand_str(input string alpha, input int n);
    string r;
    int    j;
    r = "";
    for (int i = 0; i < n; i++) begin
      j = $urandom_range(alpha.len() - 1);
      r = {r, alpha.substr(j, j)};
    end
    return r;
  endfunction

  task automatic send_string(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      isstring  = 1'b1;
      ispattern = 1'b0;
      chardata  = s[i];
    end
    @(negedge clk);
    isstring = 1'b0;
    chardata = '0;
  endtask

  task automatic send_pattern(input string p);
    for (int i = 0; i < p.len(); i++) begin
      @(negedge clk);
      ispattern = 1'b1;
      chardata  = p[i];
    end
    @(negedge clk);
    ispattern = 1'b0;
    chardata  = '0;
  endtask

  task automatic run_pattern(input string tag, input string s, input string p,
                             input bit noise);
    bit m_exp;
    int i_exp, c, sl;
    bit got;
    ref_match(s, p, m_exp, i_exp);
    sl = (s.len() > 32) ? 32 : s.len();
    send_pattern(p);
    got = 1'b0;
    c   = 0;
    while (!got && c < 40) begin
      @(negedge clk);
      c++;
      if (valid === 1'b1) begin
        got       = 1'b1;
        ispattern = 1'b0;
      end else if (noise && c >= 2 && c <= 5) begin
        ispattern = 1'b1;
        chardata  = 8'($urandom);
      end else begin
        ispattern = 1'b0;
      end
    end
    ispattern = 1'b0;
    chk({tag, " valid"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, " match"}, 32'(match), 32'(m_exp));
      chk({tag, " index"}, 32'(match_index), 32'(i_exp % 32));
      chk({tag, " latency"}, 32'(c - 1 <= sl + 2), 32'd1);
      @(negedge clk);
      chk({tag, " pulse width"}, 32'(valid), 32'd0);
      chk({tag, " hold"}, 32'(match), 32'(m_exp));
      if (noise) begin
        int extra = 0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (valid === 1'b1) extra++;
        end
        chk({tag, " single pulse"}, 32'(extra), 32'd0);
      end
    end
  endtask

  initial begin
    string hw, s32, cur, p;
    int pulses;
    hw = "hello world";
    reset = 1'b1;
    chardata = '0;
    isstring = 1'b0;
    ispattern = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset match", 32'(match), 32'd0);
    chk("reset index", 32'(match_index), 32'd0);
    reset = 1'b0;

    // Basic matching and string reuse
    send_string(hw);
    run_pattern("wor", hw, "wor", 1'b0);
    run_pattern("h.l", hw, "h.l", 1'b0);
    run_pattern("^wor", hw, "^wor", 1'b0);
    run_pattern("lo$", hw, "lo$", 1'b0);
    run_pattern("^ello", hw, "^ello", 1'b0);
    run_pattern("xyz", hw, "xyz", 1'b0);
    run_pattern("caret only", hw, "^", 1'b0);
    run_pattern("dollar only", hw, "$", 1'b0);
    run_pattern("literal anchors", hw, "l^$", 1'b0);
    run_pattern("9-char pattern", hw, "hello woQ", 1'b0);

    // Saturation of the string buffer, worst-case latency
    s32 = {"xxxxxxxxxxxxxxxxxxxxxxxxxxxxx", "abc"};
    send_string({s32, "z"});
    run_pattern("abc$ len32", {s32, "z"}, "abc$", 1'b0);
    run_pattern("no match len32", {s32, "z"}, "q", 1'b0);

    send_string("hello");
    run_pattern("long pattern", "hello", "hello world!", 1'b0);

    // Pattern strobes during SEARCH are ignored
    send_string(hw);
    run_pattern("noise", hw, "world", 1'b1);

    // Reset during SEARCH aborts without a result
    cur = "aaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa";
    send_string(cur);
    send_pattern("b");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort valid", 32'(valid), 32'd0);
    chk("abort match", 32'(match), 32'd0);
    chk("abort index", 32'(match_index), 32'd0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (valid === 1'b1) pulses++;
    end
    chk("abort no pulse", 32'(pulses), 32'd0);
    send_string("the cat sat");
    run_pattern("after reset", "the cat sat", "^sat$", 1'b0);

    // Randomized strings and patterns against the reference
    cur = "";
    for (int it = 0; it < 40; it++) begin
      if (it % 3 == 0) begin
        cur = rand_str("ab .", $urandom_range(1, 34));
        send_string(cur);
      end
      p = rand_str("ab .^$", $urandom_range(1, 9));
      run_pattern($sformatf("rand%0d", it), cur, p, 1'(it % 5 == 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/string_match_engine.md
STRING_MATCH_ENGINE -- requirements
Module: string_match_engine

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: chardata  input  8  ASCII character, sampled on clk rise.
REQ-004 SHALL have port: isstring  input  1  chardata is a string character.
REQ-005 SHALL have port: ispattern  input  1  chardata is a pattern character.
REQ-006 SHALL have port: valid  output  1  result strobe, exactly one cycle per pattern.
REQ-007 SHALL have port: match  output  1  pattern found in current string; qualified by valid.
REQ-008 SHALL have port: match_index  output  5  start position of the match; qualified by valid.

Function
REQ-009 SHALL use FSM states IDLE, RX_STR, RX_PAT, SEARCH, OUT.
REQ-010 SHALL, in IDLE or RX_PAT, on an isstring=1 cycle, clear the string buffer, store chardata at position 0, set length to 1 and enter RX_STR.
REQ-011 SHALL, in RX_STR with isstring=1, append chardata; with isstring=0, return to IDLE and keep the string.
REQ-012 SHALL, in IDLE or RX_STR, on an ispattern=1 cycle, clear the pattern buffer, store chardata at position 0 and enter RX_PAT.
REQ-013 SHALL, in RX_PAT, append chardata while ispattern=1; on the first ispattern=0 cycle, enter SEARCH with start index s=0.
REQ-014 SHALL hold a string of at most 32 characters and a pattern of at most 8; further characters are ignored and the length saturates.
REQ-015 SHALL treat isstring=1 as taking priority when isstring and ispattern are both 1.
REQ-016 SHALL ignore both isstring and ispattern while in SEARCH or OUT.
REQ-017 SHALL treat '.' (0x2E) as matching any single string character.
REQ-018 SHALL treat '^' (0x5E) as pattern position 0 as zero-width: it is satisfied at s when s==0 or str[s-1]==0x20.
REQ-019 SHALL treat '$' (0x24) as the last pattern position as zero-width: it is satisfied at end position e when e==len or str[e]==0x20.
REQ-020 SHALL match '^' or '$' anywhere else in the pattern literally.
REQ-021 SHALL compare every non-anchor pattern character against str[s+k] in parallel, one candidate s per cycle.
REQ-022 SHALL visit candidates in order s = 0..len; a candidate whose span runs past len SHALL fail.
REQ-023 SHALL enter OUT with match=1 and match_index=s on the first passing candidate (lowest s wins).
REQ-024 SHALL enter OUT with match=0 and match_index=0 after s=len fails.
REQ-025 SHALL, in OUT, drive valid=1 for exactly one cycle and then return to IDLE.
REQ-026 SHALL hold match and match_index at their last values while valid=0.
REQ-027 SHALL have a latency of at most len+2 cycles from the first ispattern=0 cycle to valid=1 (34 cycles maximum).
REQ-028 SHALL keep the stored string across patterns, so that several patterns may follow a single string.
REQ-029 SHALL report match=0 when the pattern's non-anchor length exceeds the string length.
REQ-030 SHALL, for a pattern consisting only of anchors, report the first s that satisfies the anchors (for example "^" gives index 0).

Reset
REQ-031 SHALL, with reset=1 at a clk rise, enter IDLE and force valid=0, match=0, match_index=0, string length 0 and pattern length 0.
REQ-032 SHALL, when reset is asserted mid-SEARCH or mid-receive, abort the operation and produce no valid pulse for it.

Verification
REQ-033 SHALL cover: string "hello world", pattern "wor" -> valid, match=1, index=6; then pattern "h.l" -> match=1, index=0.
REQ-034 SHALL cover: string "hello world", patterns "^wor" -> 1,6; "lo$" -> 1,3; "^ello" -> 0,0; "xyz" -> 0,0.
REQ-035 SHALL cover: a 32-character string ending "abc", pattern "abc$" -> 1,29 with latency ≤ 34 cycles; a 33rd string character is ignored.
REQ-036 SHALL cover: a 9-character pattern whose first 8 characters match -> the result is based on the first 8 characters only; pattern "hello world!" against "hello" -> 0,0.
REQ-037 SHALL cover: reset asserted during SEARCH -> no valid, outputs are 0; a fresh string and pattern afterwards produce the correct result.
REQ-038 SHALL cover: ispattern pulses injected during SEARCH -> ignored, exactly one valid pulse, correct result.
